// File: rtl/frame_writer.sv
// Plot-stream to frame buffer bridge: turns (x, y, colour) requests into single RAM writes
// and runs a full-screen clear sweep. All outputs are registered.
module frame_writer #(
  parameter int unsigned WIDTH    = 160,
  parameter int unsigned HEIGHT   = 120,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned COLOUR_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                ready,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren,
  output logic [7:0]          drop_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic                ready_nxt;
  logic                done_nxt;
  logic                wren_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [COLOUR_W-1:0] data_nxt;
  logic [7:0]          drop_nxt;
  logic [ADDR_W-1:0]   sweep_cnt, sweep_cnt_nxt;
  logic                last_sent, last_sent_nxt;
  logic [COLOUR_W-1:0] fill_colour;
  logic                in_range;

  // y is range-checked before use, so the product always fits ADDR_W.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] px, input logic [9:0] py);
    logic [ADDR_W-1:0] xa;
    logic [ADDR_W-1:0] ya;
    xa = ADDR_W'(px);
    ya = ADDR_W'(py);
    if (WIDTH == 160) begin
      return (ya << 7) + (ya << 5) + xa;
    end else begin
      return (ya * ADDR_W'(WIDTH)) + xa;
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);

  always_comb begin
    state_nxt     = state;
    done_nxt      = 1'b0;
    wren_nxt      = 1'b0;
    addr_nxt      = mem_address;
    data_nxt      = mem_data;
    drop_nxt      = drop_count;
    sweep_cnt_nxt = sweep_cnt;
    last_sent_nxt = last_sent;

    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt     = CLEAR;
          sweep_cnt_nxt = '0;
          last_sent_nxt = 1'b0;
        end else if (plot) begin
          if (in_range) begin
            wren_nxt = 1'b1;
            addr_nxt = pix_addr(x, y);
            data_nxt = colour;
          end else begin
            drop_nxt = sat_inc8(drop_count);
          end
        end
      end

      CLEAR: begin
        // Stay in CLEAR while the final write is on the bus so ready never overlaps it.
        if (last_sent) begin
          state_nxt     = IDLE;
          done_nxt      = 1'b1;
          last_sent_nxt = 1'b0;
        end else begin
          wren_nxt = 1'b1;
          addr_nxt = sweep_cnt;
          data_nxt = fill_colour;
          if (sweep_cnt == LAST_ADDR) begin
            last_sent_nxt = 1'b1;
          end else begin
            sweep_cnt_nxt = sweep_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      drop_count  <= 8'd0;
      sweep_cnt   <= '0;
      last_sent   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ready       <= ready_nxt;
      done        <= done_nxt;
      mem_wren    <= wren_nxt;
      mem_address <= addr_nxt;
      mem_data    <= data_nxt;
      drop_count  <= drop_nxt;
      sweep_cnt   <= sweep_cnt_nxt;
      last_sent   <= last_sent_nxt;
    end
  end

  // Fill colour is pure data: only meaningful once a clear has been accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && clear) begin
      fill_colour <= clear_colour;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: stimulus queues expected writes (address, data, cycle),
// a negedge monitor pops and compares every frame buffer write.
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        plot = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [1:0]  colour = '0;
  logic        clear = 1'b0;
  logic [1:0]  clear_colour = '0;
  logic        ready;
  logic        done;
  logic [14:0] mem_address;
  logic [1:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  drop_count;

  typedef struct {
    logic [14:0] addr;
    logic [1:0]  data;
    int          cyc;
  } wr_t;

  wr_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  frame_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .clear        (clear),
    .clear_colour (clear_colour),
    .ready        (ready),
    .done         (done),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int addr, input int data, input int c);
    wr_t e;
    e.addr = addr[14:0];
    e.data = data[1:0];
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_plot(input int px, input int py, input int pc);
    plot   = 1'b1;
    x      = px[9:0];
    y      = py[9:0];
    colour = pc[1:0];
    if (px < 160 && py < 120) push(py * 160 + px, pc, cyc + 1);
    step();
    plot = 1'b0;
  endtask

  // Monitor: every write must match the head of the scoreboard, on the expected cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_write: addr %0d expected at cycle %0d, got no write at that cycle", q[0].addr, q[0].cyc);
      void'(q.pop_front());
    end
    if (mem_wren === 1'b1) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d, no write expected",
                 mem_address, mem_data, cyc);
      end else begin
        check("write_addr", int'(mem_address), int'(q[0].addr));
        check("write_data", int'(mem_data), int'(q[0].data));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 21000", cyc);
    $fatal(1);
  end

  initial begin
    int k0;
    int n;

    // Reset state
    resetn = 1'b0;
    step();
    step();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data, 0);
    check("rst_drop", drop_count, 0);
    resetn = 1'b1;
    step();

    // Single plot (5,2,3) -> address 325
    do_plot(5, 2, 3);
    step();
    check("plot_wren_after", mem_wren, 0);

    // Back-to-back plots
    do_plot(0, 0, 1);
    check("b2b_ready0", ready, 1);
    do_plot(159, 119, 2);
    check("b2b_ready1", ready, 1);
    do_plot(10, 1, 0);
    check("b2b_ready2", ready, 1);
    step();
    check("b2b_wren_after", mem_wren, 0);

    // Out-of-range plots
    do_plot(160, 0, 1);
    do_plot(0, 120, 1);
    step();
    check("oob_drop2", drop_count, 2);

    // Clear and plot together, then reset while the sweep is at address 100
    clear = 1'b1; clear_colour = 2'd2;
    plot = 1'b1; x = 10'd3; y = 10'd3; colour = 2'd1;
    k0 = cyc;
    for (int i = 0; i <= 100; i++) push(i, 2, k0 + 2 + i);
    step();
    clear = 1'b0;
    plot = 1'b0;
    check("clrplot_ready", ready, 0);
    n = 0;
    while (cyc < k0 + 102 && n < 200) begin
      if (cyc == k0 + 52) check("clrplot_drop", drop_count, 2);
      step();
      n++;
    end
    check("sweep_at_100", mem_address, 100);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("midrst_wren", mem_wren, 0);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_addr", mem_address, 0);
    check("midrst_drop", drop_count, 0);
    step();
    check("midrst_no_resume", mem_wren, 0);
    do_plot(1, 0, 3);
    step();

    // Full clear with colour 1; plot pulses during the sweep must be ignored
    clear = 1'b1; clear_colour = 2'd1;
    k0 = cyc;
    for (int i = 0; i < 19200; i++) push(i, 1, k0 + 2 + i);
    step();
    clear = 1'b0;
    check("clr_ready", ready, 0);
    check("clr_done_early", done, 0);
    n = 0;
    while (done !== 1'b1 && n < 19400) begin
      plot = (n % 7 == 0);
      x = (n % 2 == 0) ? 10'd3 : 10'd200;
      y = 10'd3;
      colour = 2'd3;
      if (done === 1'b0 && ready !== 1'b0 && cyc < k0 + 19202)
        check("clr_ready_low", ready, 0);
      step();
      n++;
    end
    plot = 1'b0;
    check("clr_done", done, 1);
    check("clr_done_cycle", cyc, k0 + 19202);
    check("clr_done_ready", ready, 1);
    step();
    check("clr_done_pulse", done, 0);
    check("clr_wren_after", mem_wren, 0);
    check("clr_drop", drop_count, 0);

    // Drop counter saturation
    for (int i = 0; i < 254; i++) do_plot(170, 5, 0);
    check("drop_254", drop_count, 254);
    for (int i = 0; i < 46; i++) do_plot(0, 500, 0);
    check("drop_sat", drop_count, 255);

    step();
    step();
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
Receiving end of the pixel-plot stream produced by the team's drawing blocks (screen painters, ball/paddle/brick drawers). It accepts x, y, colour plot requests and converts each into a single write to the 160x120, 2-bit-per-pixel frame buffer RAM, with address y*WIDTH+x. It also runs a full-screen clear sweep that fills the buffer with one colour. It sits between the drawing FSMs and the frame buffer RAM port.

Parameters:
WIDTH, 160, pixels per row
HEIGHT, 120, rows per frame
ADDR_W, 15, frame buffer address width (must hold WIDTH*HEIGHT-1)
COLOUR_W, 2, bits per pixel

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous, active-low reset
plot  input  1  plot request, valid when ready=1
x  input  10  pixel column
y  input  10  pixel row
colour  input  COLOUR_W  pixel colour for plot
clear  input  1  start full-screen clear, valid when ready=1
clear_colour  input  COLOUR_W  fill colour, sampled with clear
ready  output  1  block can accept plot/clear this cycle
done  output  1  one-cycle pulse at end of clear sweep
mem_address  output  ADDR_W  frame buffer write address
mem_data  output  COLOUR_W  frame buffer write data
mem_wren  output  1  frame buffer write enable
drop_count  output  8  saturating count of rejected out-of-range plots

Behaviour:
- Reset (resetn=0 at a clock edge) applies regardless of state, including mid-clear. After that edge: state IDLE, ready=1, done=0, mem_wren=0, mem_address=0, mem_data=0, drop_count=0. An in-progress sweep is abandoned and does not resume.
- All outputs are registered.
- States:
  - IDLE: ready=1.
  - CLEAR: ready=0, sweep in progress.
- IDLE, clear=1:
  - Latch clear_colour and enter CLEAR.
  - clear has priority over plot in the same cycle; the plot is ignored and not counted.
- IDLE, plot=1, clear=0:
  - In range (x<WIDTH and y<HEIGHT): next cycle mem_wren=1, mem_address=y*WIDTH+x truncated to ADDR_W, mem_data=colour.
  - Out of range: no write; drop_count increments, saturating at 255.
  - State stays IDLE, so back-to-back plots give one write per cycle. Latency is 1 cycle.
- IDLE, no request: mem_wren=0. mem_address and mem_data hold their last values.
- CLEAR:
  - Internal counter starts at 0. Each cycle: mem_wren=1, mem_address=counter, mem_data=latched clear_colour; counter then increments.
  - The first sweep write appears the cycle after the clear is accepted.
  - Last write is at address WIDTH*HEIGHT-1 (19199). In the cycle after that write: mem_wren=0, done=1, ready=1, state IDLE.
  - Total is exactly WIDTH*HEIGHT write cycles; the counter never wraps past the last address.
- plot and clear asserted while ready=0 are ignored: no write, no drop count, no queuing.
- done is 0 at all times other than the single cycle after the final sweep write.
- Address multiply: y is range-checked first, so the product fits ADDR_W. Use shifts and adds (y*128 + y*32) for WIDTH=160; a generic multiply is acceptable for other parameter values.

Test Plan:
- Reset, then plot x=5, y=2, colour=3 -> next cycle mem_wren=1, mem_address=325, mem_data=3; following cycle mem_wren=0.
- Back-to-back plots (0,0,c=1), (159,119,c=2), (10,1,c=0) on consecutive cycles -> writes at addresses 0, 19199, 170 on consecutive cycles with the matching colours; ready stays 1 throughout.
- Plot x=160, y=0 and then x=0, y=120 -> no mem_wren; drop_count=2. Then 300 further out-of-range plots -> drop_count=255 and holds.
- clear with clear_colour=1 -> ready=0; exactly 19200 consecutive writes to addresses 0..19199 with data 1; plot pulses during the sweep are ignored; done=1 for one cycle with ready=1; mem_wren=0 afterwards.
- clear=1 and plot=1 (x=3, y=3) in the same cycle -> sweep starts; no write to address 483 outside the sweep; drop_count unchanged.
- resetn=0 for one cycle while the sweep is at address 100 -> next cycle mem_wren=0, ready=1, done=0, mem_address=0. A subsequent plot x=1, y=0 writes address 1 one cycle later.
